// File: rtl/ula.sv
// ula: RISC-V style ALU with serial (default) or barrel (ULA_FAST_SHIFT_EN) shifter
module ula #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ula_select,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done
);
    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_SLL   = 4'd2;
    localparam logic [3:0] OP_SLT   = 4'd3;
    localparam logic [3:0] OP_SLTU  = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_OR    = 4'd8;
    localparam logic [3:0] OP_AND   = 4'd9;
    localparam logic [3:0] OP_PASSB = 4'd10;
    localparam logic [3:0] OP_AUIPC = 4'd11;

    logic [4:0]       shamt;
    logic [WIDTH-1:0] alu;
    logic             is_shift;

    assign shamt    = b[4:0];
    assign is_shift = (ula_select == OP_SLL) || (ula_select == OP_SRL) || (ula_select == OP_SRA);

    // single-cycle result for every op; shifts here double as the shamt=0 / fast path
    always_comb begin
        alu = '0;
        case (ula_select)
            OP_ADD, OP_AUIPC: alu = a + b;
            OP_SUB:           alu = a - b;
            OP_SLL:           alu = a << shamt;
            OP_SLT:           alu = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU:          alu = {{(WIDTH-1){1'b0}}, a < b};
            OP_XOR:           alu = a ^ b;
            OP_SRL:           alu = a >> shamt;
            OP_SRA:           alu = $signed(a) >>> shamt;
            OP_OR:            alu = a | b;
            OP_AND:           alu = a & b;
            OP_PASSB:         alu = b;
            default:          alu = '0;
        endcase
    end

`ifdef ULA_FAST_SHIFT_EN
    assign busy = 1'b0;

    // every accepted request completes on the next edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result <= '0;
            zero   <= 1'b1;
            done   <= 1'b0;
        end else begin
            done <= start;
            if (start) begin
                result <= alu;
                zero   <= (alu == '0);
            end
        end
    end
`else
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sh_next;
    logic [4:0]       cnt;
    logic [3:0]       op;

    // one-bit step of the latched shift direction; SRA refills with the sign bit
    always_comb begin
        sh_next = (op == OP_SLL) ? {sh[WIDTH-2:0], 1'b0}
                                 : {(op == OP_SRA) ? sh[WIDTH-1] : 1'b0, sh[WIDTH-1:1]};
    end

    // IDLE accepts requests; SHIFT walks the operand one bit per cycle until cnt expires
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            result <= '0;
            zero   <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            cnt    <= '0;
            sh     <= '0;
            op     <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    if (is_shift && shamt != 5'd0) begin
                        sh    <= a;
                        cnt   <= shamt;
                        op    <= ula_select;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        result <= alu;
                        zero   <= (alu == '0);
                        done   <= 1'b1;
                    end
                end
            end else begin
                sh  <= sh_next;
                cnt <= cnt - 5'd1;
                if (cnt == 5'd1) begin
                    result <= sh_next;
                    zero   <= (sh_next == '0);
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            end
        end
    end
`endif
endmodule

// File: doc/ula.md
ULA -- requirements
Module: ula

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL be ≥ 8.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request; operands and ula_select SHALL be sampled on the edge where start=1 and busy=0.
REQ-005 ula_select  input  4  operation code from ula_control.
REQ-006 a  input  WIDTH  operand A (rs1 or PC).
REQ-007 b  input  WIDTH  operand B (rs2 or immediate); b[4:0] is the shift amount (shamt).
REQ-008 result  output  WIDTH  registered result.
REQ-009 zero  output  1  registered, 1 when result == 0.
REQ-010 busy  output  1  1 while a multi-cycle shift is in progress.
REQ-011 done  output  1  one-cycle pulse; result/zero valid from this cycle on.

Function
REQ-012 ula_select encoding SHALL be: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B (LUI), 11 ADD (AUIPC); codes 12-15 SHALL produce result 0.
REQ-013 ADD/SUB SHALL wrap modulo 2^WIDTH; carry/overflow discarded.
REQ-014 SLT SHALL compare signed, SLTU unsigned; result 1 or 0 zero-extended.
REQ-015 SRA SHALL replicate a[WIDTH-1]; SRL/SLL SHALL fill with 0; only b[4:0] used.
REQ-016 States SHALL be IDLE and SHIFT only.
REQ-017 IDLE, accepted start, non-shift op (or shift with shamt=0): result/zero updated and done=1 on next cycle; stay IDLE (latency 1).
REQ-018 IDLE, accepted start, shift with shamt>0: load a into shift register, counter=shamt, go SHIFT, busy=1 next cycle.
REQ-019 SHIFT: shift one bit per cycle, decrement counter; after counter reaches 0, write result, pulse done, busy=0, return IDLE; total latency shamt+1 cycles.
REQ-020 start while busy=1 SHALL be ignored (no queuing); a, b, ula_select changes during SHIFT SHALL not affect the operation.
REQ-021 start asserted in the same cycle done is high SHALL be accepted (back-to-back, no bubble).
REQ-022 result and zero SHALL hold their value between done pulses.
REQ-023 done and busy SHALL never be 1 in the same cycle.

Reset
REQ-024 rst_n=0 at an edge SHALL force: state IDLE, result 0, zero 1, busy 0, done 0, counter 0.
REQ-025 Reset during SHIFT SHALL abort the operation with no done pulse.
REQ-026 start sampled with rst_n=0 SHALL be ignored.

Configuration
REQ-027 Macro ULA_FAST_SHIFT_EN: when defined, shifts SHALL use a combinational barrel shifter with latency 1 and busy SHALL stay 0; SHIFT state not built.
REQ-028 Without ULA_FAST_SHIFT_EN, the serial shifter of REQ-018/019 SHALL be used.

Verification
REQ-029 ADD a=5, b=7 -> done after 1 cycle, result 12, zero 0; SUB a=7, b=7 -> result 0, zero 1.
REQ-030 SLT a=0xFFFFFFFF, b=1 -> 1; SLTU same operands -> 0; PASS_B b=0x12345000 -> 0x12345000.
REQ-031 SRA a=0x80000000, b=4 -> busy 4 cycles, done at cycle 5, result 0xF8000000; with ULA_FAST_SHIFT_EN, done at cycle 1, busy never 1.
REQ-032 SLL a=1, b=31 in progress; start with ADD asserted mid-shift -> ignored; result 0x80000000 at cycle 32; ADD applied back-to-back on done cycle -> result next cycle.
REQ-033 SRL a=0xF0, b=8, rst_n=0 at cycle 3 -> no done pulse, result 0, zero 1, busy 0; next ADD works normally.
REQ-034 ula_select=13, a=b=0xFFFF -> result 0, zero 1, latency 1.
